// File: rtl/tpu_loop_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_loop_seq
//  Purpose  : Two-level (outer/inner) loop sequencer. It issues one operand
//             index pair per accepted beat to the TPU datapath. After the
//             final beat it waits a programmable drain interval, then pulses
//             done.
//  Revision : 1.0  initial release
// ============================================================================
module tpu_loop_seq #(
  parameter int CNT_WIDTH   = 16,
  parameter int DRAIN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,          // asynchronous, active-low
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   inner_end,
  input  logic [CNT_WIDTH-1:0]   outer_end,
  input  logic [DRAIN_WIDTH-1:0] drain_len,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [CNT_WIDTH-1:0]   inner_idx,
  output logic [CNT_WIDTH-1:0]   outer_idx,
  output logic                   first_inner,
  output logic                   last_inner,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0]   C_CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DRAIN_WIDTH-1:0] C_DRAIN_ONE = DRAIN_WIDTH'(1);

  logic [1:0]             state_q,     state_d;
  logic [CNT_WIDTH-1:0]   inner_q,     inner_d;
  logic [CNT_WIDTH-1:0]   outer_q,     outer_d;
  logic [CNT_WIDTH-1:0]   ie_q,        ie_d;
  logic [CNT_WIDTH-1:0]   oe_q,        oe_d;
  logic [DRAIN_WIDTH-1:0] dl_q,        dl_d;
  logic [DRAIN_WIDTH-1:0] dcnt_q,      dcnt_d;
  logic                   valid_q,     valid_d;
  logic                   first_q,     first_d;
  logic                   last_in_q,   last_in_d;
  logic                   last_q,      last_d;
  logic                   busy_q,      busy_d;
  logic                   done_q,      done_d;

  logic                   w_accept;

  // valid_q is high exactly in ISSUE, so it qualifies the handshake directly
  assign w_accept = valid_q & issue_ready;

  // Next-state, index stepping and registered-output computation
  always_comb begin
    state_d = state_q;
    inner_d = inner_q;
    outer_d = outer_q;
    ie_d    = ie_q;
    oe_d    = oe_q;
    dl_d    = dl_q;
    dcnt_d  = dcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ie_d    = inner_end;
          oe_d    = outer_end;
          dl_d    = drain_len;
          inner_d = '0;
          outer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_accept) begin
          if (last_q) begin
            // Park indices at zero so they never exceed their end values
            inner_d = '0;
            outer_d = '0;
            dcnt_d  = '0;
            state_d = (dl_q == '0) ? S_DONE : S_DRAIN;
          end else if (last_in_q) begin
            inner_d = '0;
            outer_d = outer_q + C_CNT_ONE;
          end else begin
            inner_d = inner_q + C_CNT_ONE;
          end
        end
      end
      S_DRAIN: begin
        // dl_q is non-zero here, so the subtraction cannot wrap
        if (dcnt_q == dl_q - C_DRAIN_ONE) begin
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + C_DRAIN_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel wins over everything outside IDLE; no done pulse follows
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      inner_d = '0;
      outer_d = '0;
    end

    // Flags are precomputed from next-state values so every output is a flop
    valid_d   = (state_d == S_ISSUE);
    first_d   = valid_d && (inner_d == '0);
    last_in_d = valid_d && (inner_d == ie_d);
    last_d    = last_in_d && (outer_d == oe_d);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      inner_q   <= '0;
      outer_q   <= '0;
      ie_q      <= '0;
      oe_q      <= '0;
      dl_q      <= '0;
      dcnt_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_in_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      inner_q   <= inner_d;
      outer_q   <= outer_d;
      ie_q      <= ie_d;
      oe_q      <= oe_d;
      dl_q      <= dl_d;
      dcnt_q    <= dcnt_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_in_q <= last_in_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign issue_valid = valid_q;
  assign inner_idx   = inner_q;
  assign outer_idx   = outer_q;
  assign first_inner = first_q;
  assign last_inner  = last_in_q;
  assign last        = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_loop_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tpu_loop_seq
//  Purpose  : Self-checking bench for tpu_loop_seq. Each job's expected beat
//             list is built from nested loops. The expected timeline (drain,
//             done, idle) is derived from the cycle of the last accepted beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tpu_loop_seq;

  localparam int CW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          issue_ready = 1'b0;
  logic [CW-1:0] inner_end = '0;
  logic [CW-1:0] outer_end = '0;
  logic [DW-1:0] drain_len = '0;

  logic          issue_valid;
  logic [CW-1:0] inner_idx;
  logic [CW-1:0] outer_idx;
  logic          first_inner;
  logic          last_inner;
  logic          last;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  tpu_loop_seq #(.CNT_WIDTH(CW), .DRAIN_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .inner_end   (inner_end),
    .outer_end   (outer_end),
    .drain_len   (drain_len),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .inner_idx   (inner_idx),
    .outer_idx   (outer_idx),
    .first_inner (first_inner),
    .last_inner  (last_inner),
    .last        (last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the three control outputs in one go
  task automatic chk_ctl(input string tag, input bit v, input bit b, input bit d);
    chk({tag, ".valid"}, 32'(issue_valid), 32'(v));
    chk({tag, ".busy"},  32'(busy),        32'(b));
    chk({tag, ".done"},  32'(done),        32'(d));
  endtask

  function automatic bit rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // One job from start (cycle 0) to the first IDLE cycle. Returns in that
  // IDLE cycle at #1 after its edge, so the next job can start there.
  task automatic run_job(input int ie, input int oe, input int dl, input int mode,
                         input int abort_at, input bit glitch);
    int qi[$];
    int qo[$];
    int total;
    int ptr = 0;
    int k = -1;
    int cyc;
    bit aborted = 1'b0;

    for (int o = 0; o <= oe; o++)
      for (int i = 0; i <= ie; i++) begin
        qi.push_back(i);
        qo.push_back(o);
      end
    total = qi.size();

    start = 1'b1; abort = 1'b0;
    inner_end = CW'(ie); outer_end = CW'(oe); drain_len = DW'(dl);
    issue_ready = rdy(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;

    forever begin
      if (cyc > 400) begin
        chk("cycle_budget", 32'(cyc), 32'(400));
        break;
      end
      if (aborted) begin
        chk_ctl("abort_idle", 1'b0, 1'b0, 1'b0);
        repeat (2) begin
          @(posedge clk); #1;
          chk_ctl("abort_nodone", 1'b0, 1'b0, 1'b0);
        end
        break;
      end
      if (ptr < total) begin
        chk_ctl("issue", 1'b1, 1'b1, 1'b0);
        chk("inner_idx",   32'(inner_idx),   32'(qi[ptr]));
        chk("outer_idx",   32'(outer_idx),   32'(qo[ptr]));
        chk("first_inner", 32'(first_inner), 32'(qi[ptr] == 0));
        chk("last_inner",  32'(last_inner),  32'(qi[ptr] == ie));
        chk("last",        32'(last),        32'(ptr == total - 1));
      end else if (cyc - k <= dl) begin
        chk_ctl("drain", 1'b0, 1'b1, 1'b0);
      end else if (cyc - k == dl + 1) begin
        chk_ctl("done", 1'b0, 1'b1, 1'b1);
      end else begin
        chk_ctl("idle", 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        if (glitch) begin
          // The start raised during the DONE cycle must not have launched
          @(posedge clk); #1;
          chk_ctl("done_start_ignored", 1'b0, 1'b0, 1'b0);
        end
        break;
      end

      issue_ready = rdy(mode, cyc);
      if (glitch) begin
        start     = (ptr >= total && cyc - k == dl + 1) ? 1'b1 : 1'($urandom_range(0, 1));
        inner_end = CW'($urandom_range(0, 7));
        outer_end = CW'($urandom_range(0, 7));
        drain_len = DW'($urandom_range(0, 7));
      end
      if (ptr < total && issue_ready) begin
        ptr++;
        if (ptr == total) k = cyc;
      end
      if (cyc == abort_at) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    // Reset values visible without any clock edge
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.inner", 32'(inner_idx), 32'(0));
    chk("reset.outer", 32'(outer_idx), 32'(0));
    chk("reset.flags", 32'({first_inner, last_inner, last}), 32'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_ctl("post_reset", 1'b0, 1'b0, 1'b0);

    // Basic job
    run_job(2, 1, 4, 0, -1, 1'b0);
    // Backpressure on odd cycles
    run_job(2, 1, 4, 1, -1, 1'b0);
    // Degenerate sizes
    run_job(0, 0, 0, 0, -1, 1'b0);
    // Abort in cycle 3, then a clean restart
    run_job(2, 1, 4, 0, 3, 1'b0);
    run_job(2, 1, 4, 0, -1, 1'b0);
    // Ignored start / config changes during a job, start on the DONE cycle
    run_job(3, 2, 2, 0, -1, 1'b1);
    run_job(1, 2, 0, 1, -1, 1'b1);

    // Randomized jobs and backpressure
    for (int n = 0; n < 8; n++)
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 5)), 2, -1, 1'(n % 2));

    // Asynchronous reset in the middle of ISSUE
    start = 1'b1; inner_end = CW'(5); outer_end = CW'(5); drain_len = DW'(3);
    issue_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk_ctl("pre_areset", 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    chk_ctl("areset", 1'b0, 1'b0, 1'b0);
    chk("areset.inner", 32'(inner_idx), 32'(0));
    chk("areset.outer", 32'(outer_idx), 32'(0));
    chk("areset.flags", 32'({first_inner, last_inner, last}), 32'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_ctl("after_areset", 1'b0, 1'b0, 1'b0);
    run_job(1, 1, 1, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
